// File: rtl/auth_resp_tx_framer.sv
// ----------------------------------------------------------------------------
// auth_resp_tx_framer
//
// Output stage of the authentication responder. When the responder raises
// its request level, the finished response (header, payload, USB control
// fields, timeout) is captured into shadow registers. The block then offers
// an 8-byte USB SETUP word and streams the data stage one byte at a time.
// Completion returns a one-cycle Ack_out. The whole transfer is bounded by
// the timeout the responder supplied.
//
// Handshake semantics (both SETUP and data stage): a transfer happens on a
// rising clk edge where valid and ready are both high. Once valid is raised,
// the data (and tx_last) stay stable until that transfer. Valid only drops
// without a transfer on abort, timeout or reset. Ready may change freely.
//
// Ports
//   clk              single clock, rising edge
//   reset            asynchronous, active-low
//   resp_req_in      request level from the responder
//   header[31:0]     {ProtocolVersion, MessageType, Param1, Param2}
//   payload[PW-1:0]  payload, byte 0 in the top bits
//   bmRequestType,
//   bRequest,
//   wLength          USB control fields for the SETUP packet
//   current_timeout  transfer budget in clk cycles (0 = no timeout)
//   Ack_out          one-cycle completion pulse back to the responder
//   setup_valid/setup_data/setup_ready     SETUP handshake
//   tx_valid/tx_data/tx_last/tx_ready      data-stage handshake
//   timeout_err      one-cycle pulse when the budget runs out
//   busy             high whenever the FSM is not idle
//   dbg_state_o      current FSM state, for checkers
// ----------------------------------------------------------------------------
module auth_resp_tx_framer #(
    parameter int PAYLOAD_W = 2048
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 resp_req_in,
    input  logic [31:0]          header,
    input  logic [PAYLOAD_W-1:0] payload,
    input  logic [7:0]           bmRequestType,
    input  logic [7:0]           bRequest,
    input  logic [15:0]          wLength,
    input  logic [31:0]          current_timeout,
    output logic                 Ack_out,
    output logic                 setup_valid,
    output logic [63:0]          setup_data,
    input  logic                 setup_ready,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    output logic                 tx_last,
    input  logic                 tx_ready,
    output logic                 timeout_err,
    output logic                 busy,
    output logic [2:0]           dbg_state_o
);

    localparam int          FRAME_BYTES = 4 + PAYLOAD_W / 8;
    localparam int          FRAME_W     = 32 + PAYLOAD_W;
    localparam logic [16:0] FRAME_LEN   = 17'(FRAME_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LATCH    = 3'd1,
        ST_SETUP    = 3'd2,
        ST_DATA     = 3'd3,
        ST_DONE     = 3'd4,
        ST_WAIT_LOW = 3'd5
    } state_e;

    state_e               state_q,      state_d;
    logic [FRAME_W-1:0]   frame_q,      frame_d;       // header+payload, shifted out MSB-first
    logic [63:0]          setup_data_q, setup_data_d;
    logic [15:0]          rem_q,        rem_d;         // bytes not yet loaded into tx_data
    logic [31:0]          tmo_q,        tmo_d;
    logic                 tmo_en_q,     tmo_en_d;
    logic                 tx_valid_q,   tx_valid_d;
    logic [7:0]           tx_data_q,    tx_data_d;
    logic                 tx_last_q,    tx_last_d;
    logic                 tmo_err_q,    tmo_err_d;

    logic                 setup_hs;
    logic                 tx_hs;
    logic                 tmo_expire;
    logic                 req_low;
    logic [15:0]          clamp_len;

    // The data stage never runs past the frame, however large wLength is.
    // The SETUP word still carries the unclamped wLength.
    assign clamp_len = ({1'b0, wLength} > FRAME_LEN) ? FRAME_LEN[15:0] : wLength;

    assign setup_hs   = (state_q == ST_SETUP) && setup_ready;
    assign tx_hs      = tx_valid_q && tx_ready;
    // Counter is about to step from 1 to 0 on this edge.
    assign tmo_expire = tmo_en_q && (tmo_q == 32'd1);
    assign req_low    = !resp_req_in;

    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        setup_data_d = setup_data_q;
        rem_d        = rem_q;
        tmo_d        = tmo_q;
        tmo_en_d     = tmo_en_q;
        tx_valid_d   = tx_valid_q;
        tx_data_d    = tx_data_q;
        tx_last_d    = tx_last_q;
        tmo_err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (resp_req_in) begin
                    state_d = ST_LATCH;
                end
            end

            ST_LATCH: begin
                if (req_low) begin
                    state_d = ST_IDLE;
                end else begin
                    frame_d      = {header, payload};
                    setup_data_d = {wLength, 32'h0000_0000, bRequest, bmRequestType};
                    rem_d        = clamp_len;
                    tmo_d        = current_timeout;
                    tmo_en_d     = (current_timeout != 32'd0);
                    state_d      = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (tmo_en_q) begin
                    tmo_d = tmo_q - 32'd1;
                end
                // Priority: abort, then completion, then timeout.
                if (req_low) begin
                    state_d = ST_IDLE;
                end else if (setup_hs && (rem_q == 16'd0)) begin
                    state_d = ST_DONE;
                end else if (tmo_expire) begin
                    tmo_err_d = 1'b1;
                    state_d   = ST_WAIT_LOW;
                end else if (setup_hs) begin
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                if (tmo_en_q) begin
                    tmo_d = tmo_q - 32'd1;
                end
                if (req_low) begin
                    tx_valid_d = 1'b0;
                    tx_last_d  = 1'b0;
                    state_d    = ST_IDLE;
                end else if (tx_hs && tx_last_q) begin
                    tx_valid_d = 1'b0;
                    tx_last_d  = 1'b0;
                    state_d    = ST_DONE;
                end else if (tmo_expire) begin
                    tx_valid_d = 1'b0;
                    tx_last_d  = 1'b0;
                    tmo_err_d  = 1'b1;
                    state_d    = ST_WAIT_LOW;
                end else if (!tx_valid_q || tx_hs) begin
                    // First DATA cycle (nothing presented yet) or the current
                    // byte was just taken: present the next frame byte.
                    tx_valid_d = 1'b1;
                    tx_data_d  = frame_q[FRAME_W-1 -: 8];
                    tx_last_d  = (rem_q == 16'd1);
                    rem_d      = rem_q - 16'd1;
                    frame_d    = {frame_q[FRAME_W-9:0], 8'h00};
                end
            end

            ST_DONE: begin
                state_d = ST_WAIT_LOW;
            end

            ST_WAIT_LOW: begin
                // Hold here until the responder drops its request so a
                // still-high level cannot start a second transfer.
                if (req_low) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            frame_q      <= '0;
            setup_data_q <= '0;
            rem_q        <= '0;
            tmo_q        <= '0;
            tmo_en_q     <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= '0;
            tx_last_q    <= 1'b0;
            tmo_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            setup_data_q <= setup_data_d;
            rem_q        <= rem_d;
            tmo_q        <= tmo_d;
            tmo_en_q     <= tmo_en_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            tx_last_q    <= tx_last_d;
            tmo_err_q    <= tmo_err_d;
        end
    end

    assign Ack_out     = (state_q == ST_DONE);
    assign setup_valid = (state_q == ST_SETUP);
    assign setup_data  = setup_data_q;
    assign tx_valid    = tx_valid_q;
    assign tx_data     = tx_data_q;
    assign tx_last     = tx_last_q;
    assign timeout_err = tmo_err_q;
    assign busy        = (state_q != ST_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_auth_resp_tx_framer.sv
module tb_auth_resp_tx_framer;
  localparam int PW    = 2048;
  localparam int FRAME = 4 + PW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          resp_req_in;
  logic [31:0]   header;
  logic [PW-1:0] payload;
  logic [7:0]    bmRequestType;
  logic [7:0]    bRequest;
  logic [15:0]   wLength;
  logic [31:0]   current_timeout;
  logic          Ack_out;
  logic          setup_valid;
  logic [63:0]   setup_data;
  logic          setup_ready;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_last;
  logic          tx_ready;
  logic          timeout_err;
  logic          busy;
  logic [2:0]    dbg_state_o;

  auth_resp_tx_framer #(.PAYLOAD_W(PW)) dut (
    .clk(clk), .reset(reset), .resp_req_in(resp_req_in),
    .header(header), .payload(payload),
    .bmRequestType(bmRequestType), .bRequest(bRequest), .wLength(wLength),
    .current_timeout(current_timeout), .Ack_out(Ack_out),
    .setup_valid(setup_valid), .setup_data(setup_data), .setup_ready(setup_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready),
    .timeout_err(timeout_err), .busy(busy), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- scoreboard state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] setup_exp_q[$];
  logic [8:0]  tx_exp_q[$];     // {last, data}

  int   t0;
  int   ack_seen, err_seen, ack_cyc, err_cyc;
  int   setup_cyc, last_tx_cyc, first_sv_cyc, first_tv_cyc, tx_cnt;
  int   rdy_mode = 0;           // 0 all ready, 1 tx toggles, 2 random, 3 setup never ready
  logic [7:0] pay_b[256];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- ready drivers ----------------
  initial begin
    setup_ready = 1'b0;
    tx_ready    = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: begin setup_ready = 1'b1; tx_ready = 1'b1; end
        1: begin setup_ready = 1'b1; tx_ready = ~tx_ready; end
        2: begin setup_ready = 1'($urandom_range(0, 1)); tx_ready = 1'($urandom_range(0, 1)); end
        default: begin setup_ready = 1'b0; tx_ready = 1'b1; end
      endcase
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    bit         prev_ack, prev_err, prev_stall;
    logic [8:0] prev_tx;
    logic [63:0] exp_s;
    logic [8:0]  exp_b;
    prev_ack = 0; prev_err = 0; prev_stall = 0; prev_tx = '0;
    forever begin
      @(negedge clk);
      if (setup_valid && first_sv_cyc < 0) first_sv_cyc = cyc;
      if (tx_valid && first_tv_cyc < 0) first_tv_cyc = cyc;
      if (setup_valid && setup_ready) begin
        setup_cyc = cyc;
        if (setup_exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL setup_extra: got setup_data %0h, expected no SETUP handshake", setup_data);
        end else begin
          exp_s = setup_exp_q.pop_front();
          check("setup_data", setup_data, exp_s);
        end
      end
      if (prev_stall && tx_valid) check("tx_stable", {tx_last, tx_data}, prev_tx);
      if (tx_valid && tx_ready) begin
        tx_cnt++;
        last_tx_cyc = cyc;
        if (tx_exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL tx_extra: got byte %0h last %0b, expected no data handshake", tx_data, tx_last);
        end else begin
          exp_b = tx_exp_q.pop_front();
          check("tx_byte", {tx_last, tx_data}, exp_b);
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_tx    = {tx_last, tx_data};
      if (Ack_out) begin
        check("ack_width", {63'b0, prev_ack}, 64'd0);
        ack_seen++;
        ack_cyc = cyc;
      end
      if (timeout_err) begin
        check("err_width", {63'b0, prev_err}, 64'd0);
        err_seen++;
        err_cyc = cyc;
      end
      prev_ack = Ack_out;
      prev_err = timeout_err;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic begin_xfer(input logic [31:0] hdr, input logic [7:0] bm, input logic [7:0] br,
                            input int wl, input logic [31:0] tmo, input bit idx_pay,
                            input bit exp_setup, input bit exp_bytes);
    logic [PW-1:0] pv;
    logic [7:0]    b;
    int            n;
    @(posedge clk);
    #1;
    for (int i = 0; i < 256; i++) pay_b[i] = idx_pay ? 8'(i) : 8'($urandom_range(0, 255));
    for (int i = 0; i < 256; i++) pv[PW-1-8*i -: 8] = pay_b[i];
    header = hdr; payload = pv; bmRequestType = bm; bRequest = br;
    wLength = 16'(wl); current_timeout = tmo;
    // Reference: SETUP word from the raw fields, then the frame bytes in order.
    n = (wl > FRAME) ? FRAME : wl;
    if (exp_setup) setup_exp_q.push_back({16'(wl), 32'h0, br, bm});
    if (exp_bytes) begin
      for (int k = 0; k < n; k++) begin
        b = (k < 4) ? hdr[31-8*k -: 8] : pay_b[k-4];
        tx_exp_q.push_back({k == n - 1, b});
      end
    end
    ack_seen = 0; err_seen = 0; ack_cyc = -1; err_cyc = -1;
    setup_cyc = -1; last_tx_cyc = -1; first_sv_cyc = -1; first_tv_cyc = -1; tx_cnt = 0;
    resp_req_in = 1'b1;
    t0 = cyc;
  endtask

  // Inputs are changed after capture; the transfer must not notice.
  task automatic scramble();
    header = $urandom;
    for (int i = 0; i < PW / 32; i++) payload[32*i +: 32] = $urandom;
    bmRequestType = 8'($urandom);
    bRequest = 8'($urandom);
    wLength = 16'($urandom);
    current_timeout = $urandom;
  endtask

  task automatic wait_end(input int budget, input string tag);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      #1;
      if (cyc == t0 + 2) scramble();
      if (ack_seen > 0 || err_seen > 0) done = 1;
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL %s.wait: no Ack_out or timeout_err within %0d cycles", tag, budget);
    end
  endtask

  task automatic wait_tx_cnt(input int target, input string tag);
    bit done;
    done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      #1;
      if (tx_cnt >= target) done = 1;
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL %s.wait_tx: got %0d bytes, expected %0d", tag, tx_cnt, target);
    end
  endtask

  task automatic release_req(input string tag);
    @(posedge clk);
    #1;
    resp_req_in = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, ".idle_after_release"}, {63'b0, busy}, 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".Ack_out"}, {63'b0, Ack_out}, 64'd0);
    check({tag, ".setup_valid"}, {63'b0, setup_valid}, 64'd0);
    check({tag, ".setup_data"}, setup_data, 64'd0);
    check({tag, ".tx_valid"}, {63'b0, tx_valid}, 64'd0);
    check({tag, ".tx_data"}, {56'b0, tx_data}, 64'd0);
    check({tag, ".tx_last"}, {63'b0, tx_last}, 64'd0);
    check({tag, ".timeout_err"}, {63'b0, timeout_err}, 64'd0);
    check({tag, ".busy"}, {63'b0, busy}, 64'd0);
  endtask

  task automatic run_ok(input logic [31:0] hdr, input logic [7:0] bm, input logic [7:0] br,
                        input int wl, input logic [31:0] tmo, input int mode,
                        input bit idx_pay, input int hold, input string tag);
    int n, sv_cnt;
    n = (wl > FRAME) ? FRAME : wl;
    rdy_mode = mode;
    begin_xfer(hdr, bm, br, wl, tmo, idx_pay, 1, 1);
    wait_end(3000, tag);
    check({tag, ".ack_count"}, 64'(ack_seen), 64'd1);
    check({tag, ".err_count"}, 64'(err_seen), 64'd0);
    check({tag, ".first_setup_valid"}, 64'(first_sv_cyc - t0), 64'd2);
    check({tag, ".setup_left"}, 64'(setup_exp_q.size()), 64'd0);
    check({tag, ".bytes_left"}, 64'(tx_exp_q.size()), 64'd0);
    if (n > 0) begin
      check({tag, ".tx_count"}, 64'(tx_cnt), 64'(n));
      check({tag, ".ack_after_last"}, 64'(ack_cyc), 64'(last_tx_cyc + 1));
      check({tag, ".first_tx_valid"}, 64'(first_tv_cyc), 64'(setup_cyc + 2));
      if (mode == 0) check({tag, ".latency"}, 64'(ack_cyc - t0), 64'(4 + n));
    end else begin
      check({tag, ".ack_after_setup"}, 64'(ack_cyc), 64'(setup_cyc + 1));
      check({tag, ".no_tx_valid"}, 64'(first_tv_cyc), 64'(-1));
    end
    if (hold > 0) begin
      sv_cnt = 0;
      repeat (hold) begin
        @(negedge clk);
        if (setup_valid) sv_cnt++;
      end
      check({tag, ".no_retrigger"}, 64'(sv_cnt), 64'd0);
      check({tag, ".busy_while_held"}, {63'b0, busy}, 64'd1);
      check({tag, ".ack_once"}, 64'(ack_seen), 64'd1);
    end
    release_req(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int wl, sel, mode;
    logic [31:0] tmo;
    reset = 1'b0;
    resp_req_in = 1'b0;
    header = '0; payload = '0; bmRequestType = '0; bRequest = '0;
    wLength = '0; current_timeout = '0;
    #2;
    check_all_zero("reset_state");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Digest-style response: header 01010000, payload bytes = index.
    run_ok(32'h0101_0000, 8'h80, 8'h18, 260, 32'd1000, 0, 1, 0, "digest");

    // Zero-length response.
    run_ok($urandom, 8'h80, 8'h06, 0, 32'd100, 0, 0, 0, "zero_len");

    // Backpressure: tx_ready toggles every cycle.
    run_ok($urandom, 8'hC0, 8'h01, 8, 32'd0, 1, 0, 0, "backpressure");

    // Timeout while SETUP is never accepted.
    rdy_mode = 3;
    begin_xfer($urandom, 8'h80, 8'h01, 8, 32'd5, 0, 0, 0);
    wait_end(100, "tmo_setup");
    check("tmo_setup.err_count", 64'(err_seen), 64'd1);
    check("tmo_setup.ack_count", 64'(ack_seen), 64'd0);
    check("tmo_setup.err_time", 64'(err_cyc - t0), 64'd7);
    @(negedge clk);
    check("tmo_setup.setup_valid_after", {63'b0, setup_valid}, 64'd0);
    check("tmo_setup.busy_wait_low", {63'b0, busy}, 64'd1);
    release_req("tmo_setup");

    // Timeout one cycle before the last data handshake.
    rdy_mode = 0;
    begin_xfer($urandom, 8'h80, 8'h02, 10, 32'd11, 0, 1, 1);
    wait_end(100, "tmo_data");
    check("tmo_data.err_count", 64'(err_seen), 64'd1);
    check("tmo_data.ack_count", 64'(ack_seen), 64'd0);
    check("tmo_data.err_time", 64'(err_cyc - t0), 64'd13);
    @(negedge clk);
    check("tmo_data.tx_valid_after", {63'b0, tx_valid}, 64'd0);
    setup_exp_q.delete(); tx_exp_q.delete();
    release_req("tmo_data");

    // Completing handshake on the cycle the counter would reach zero.
    run_ok($urandom, 8'h80, 8'h03, 10, 32'd12, 0, 0, 0, "tmo_vs_done");

    // Abort while byte 3 is presented.
    rdy_mode = 0;
    begin_xfer($urandom, 8'h80, 8'h04, 20, 32'd0, 0, 1, 1);
    wait_tx_cnt(4, "abort");
    resp_req_in = 1'b0;
    @(negedge clk);
    check("abort.tx_valid", {63'b0, tx_valid}, 64'd0);
    check("abort.setup_valid", {63'b0, setup_valid}, 64'd0);
    check("abort.busy", {63'b0, busy}, 64'd0);
    repeat (3) @(negedge clk);
    check("abort.ack_count", 64'(ack_seen), 64'd0);
    check("abort.err_count", 64'(err_seen), 64'd0);
    setup_exp_q.delete(); tx_exp_q.delete();

    // Abort on the same cycle the timeout would expire.
    rdy_mode = 3;
    begin_xfer($urandom, 8'h80, 8'h05, 8, 32'd5, 0, 0, 0);
    for (int i = 0; i < 20 && cyc < t0 + 6; i++) begin
      @(negedge clk);
      #1;
    end
    resp_req_in = 1'b0;
    @(negedge clk);
    check("abort_vs_tmo.busy", {63'b0, busy}, 64'd0);
    check("abort_vs_tmo.setup_valid", {63'b0, setup_valid}, 64'd0);
    repeat (3) @(negedge clk);
    check("abort_vs_tmo.err_count", 64'(err_seen), 64'd0);
    check("abort_vs_tmo.ack_count", 64'(ack_seen), 64'd0);

    // Asynchronous reset in the middle of the data stage.
    rdy_mode = 0;
    begin_xfer($urandom, 8'h80, 8'h06, 40, 32'd0, 0, 1, 1);
    wait_tx_cnt(5, "reset_mid");
    reset = 1'b0;
    #1;
    check_all_zero("reset_mid");
    resp_req_in = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    setup_exp_q.delete(); tx_exp_q.delete();
    @(negedge clk);
    check("reset_mid.idle", {63'b0, busy}, 64'd0);

    // No retrigger while the request stays high; a fresh request works.
    run_ok($urandom, 8'h80, 8'h07, 6, 32'd0, 0, 0, 10, "no_retrigger");
    run_ok($urandom, 8'h80, 8'h08, 6, 32'd0, 0, 0, 0, "retrigger");

    // wLength beyond the frame.
    run_ok($urandom, 8'h80, 8'h09, 1000, 32'd0, 0, 0, 0, "oversize");

    // Randomized transfers.
    for (int t = 0; t < 12; t++) begin
      sel  = $urandom_range(0, 3);
      mode = $urandom_range(0, 2);
      case (sel)
        0:       wl = $urandom_range(0, 3);
        1:       wl = $urandom_range(1, 40);
        2:       wl = $urandom_range(250, 270);
        default: wl = $urandom_range(261, 65535);
      endcase
      tmo = ($urandom_range(0, 1) == 1) ? 32'd0 : 32'd5000;
      run_ok($urandom, 8'($urandom), 8'($urandom), wl, tmo, mode, 0, 0, "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

endmodule
